// File: rtl/serial_parity_receiver.sv
// rtl/serial_parity_receiver.sv - serial frame receiver with parity/framing check and saturating error count
module serial_parity_receiver #(
  parameter int DATA_W     = 3,
  parameter bit ODD_PARITY = 1'b0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic [DATA_W-1:0]    data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_count
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic [DATA_W-1:0]      shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   par_q, par_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   busy_q, busy_d;
  logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

  // Next-state: frame walk on qualified bits, result capture on the stop bit, error counting
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    cnt_d        = cnt_q;
    par_d        = par_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    err_count_d  = err_count_q;

    if (bit_valid) begin
      unique case (state_q)
        IDLE: begin
          if (!bit_in) begin
            state_d = DATA;
            cnt_d   = '0;
            par_d   = ODD_PARITY;
          end
        end
        DATA: begin
          shift_d[cnt_q] = bit_in;
          par_d          = par_q ^ bit_in;
          if (cnt_q == LAST_BIT) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        PARITY: begin
          par_d   = par_q ^ bit_in;
          state_d = STOP;
        end
        STOP: begin
          data_out_d   = shift_q;
          parity_err_d = par_q;
          frame_err_d  = ~bit_in;
          data_valid_d = 1'b1;
          state_d      = IDLE;
          // Count the bad frame on the same edge its flags are captured
          if ((par_q || !bit_in) && (err_count_q != {ERR_CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Clear takes priority over a coincident increment
    if (clr_count) begin
      err_count_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset discards any partial frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      par_q        <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      par_q        <= par_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign err_count  = err_count_q;

endmodule
